// File: rtl/miriscv_data_arbiter.sv
// Two-master arbiter for the miriscv_ram data port: master 0 has fixed priority,
// a starvation counter bounds master 1's wait, and read data is routed to the requester.
module miriscv_data_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            starve_hit;
  logic            resp_valid_q;
  logic            resp_owner_q;

  assign starve_hit = (starve_cnt_q == CntW'(STARVE_LIMIT));

  // Grants are suppressed during reset so nothing reaches the RAM.
  assign m1_gnt_o = ~rst_i & m1_req_i & (~m0_req_i | starve_hit);
  assign m0_gnt_o = ~rst_i & m0_req_i & ~m1_gnt_o;

  always_comb begin
    ram_req_o   = m0_gnt_o | m1_gnt_o;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (m1_gnt_o) begin
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_be_i;
      ram_addr_o  = m1_addr_i;
      ram_wdata_o = m1_wdata_i;
    end else if (m0_gnt_o) begin
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_be_i;
      ram_addr_o  = m0_addr_i;
      ram_wdata_o = m0_wdata_i;
    end
  end

  // Saturation is only reachable while master 1 is being forced through.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req_i || m1_gnt_o) begin
      starve_cnt_d = '0;
    end else if (!starve_hit) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_valid_q <= ram_req_o;
      resp_owner_q <= m1_gnt_o;
    end
  end

  assign m0_rvalid_o = resp_valid_q & ~resp_owner_q & ~rst_i;
  assign m1_rvalid_o = resp_valid_q &  resp_owner_q & ~rst_i;
  assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Directed bench for miriscv_data_arbiter with a small one-cycle-latency RAM model.
module tb_miriscv_data_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  miriscv_data_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_be_i     (m0_be),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_be_i     (m1_be),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read of the pre-write word, byte-enabled write.
  always @(posedge clk) begin
    if (ram_req) begin
      ram_rdata <= mem[ram_addr[7:2]];
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_drive(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic m1_drive(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic idle();
    m0_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    m1_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      m0_drive(1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678);
      m1_drive(1'b1, 1'b1, 4'hF, 32'h0000_0044, 32'h8765_4321);
      #1;
      n_checks++;
      if ({m0_gnt, m1_gnt, ram_req, m0_rvalid, m1_rvalid} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs c=%0d got gnt0=%b gnt1=%b req=%b rv0=%b rv1=%b want all 0",
                 c, m0_gnt, m1_gnt, ram_req, m0_rvalid, m1_rvalid);
      end
      n_checks++;
      if ({ram_we, ram_be, ram_addr, ram_wdata} !== 69'b0) begin
        n_fail++;
        $display("FAIL reset_ram_port c=%0d got we=%b be=%h addr=%h wdata=%h want 0",
                 c, ram_we, ram_be, ram_addr, ram_wdata);
      end
    end
    tick();
    rst = 1'b0;
    m0_drive(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
    m1_drive(1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0);
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release got gnt0=%b gnt1=%b rv0=%b rv1=%b want 1 0 0 0",
               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_cross_master();
    m0_drive(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (!(m0_gnt === 1'b1 && ram_we === 1'b1 && ram_addr === 32'h10 &&
          ram_wdata === 32'hDEAD_BEEF && ram_be === 4'hF)) begin
      n_fail++;
      $display("FAIL cross_write got gnt0=%b we=%b addr=%h wdata=%h be=%h want 1 1 10 deadbeef f",
               m0_gnt, ram_we, ram_addr, ram_wdata, ram_be);
    end
    tick();
    idle();
    m1_drive(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    #1;
    n_checks++;
    if ({m1_gnt, m0_rvalid, m1_rvalid, ram_we} !== 4'b1100) begin
      n_fail++;
      $display("FAIL cross_read_issue got gnt1=%b rv0=%b rv1=%b we=%b want 1 1 0 0",
               m1_gnt, m0_rvalid, m1_rvalid, ram_we);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (!(m1_rvalid === 1'b1 && m1_rdata === 32'hDEAD_BEEF && m0_rdata === 32'h0 &&
          m0_rvalid === 1'b0)) begin
      n_fail++;
      $display("FAIL cross_read_resp got rv1=%b rd1=%h rd0=%h rv0=%b want 1 deadbeef 0 0",
               m1_rvalid, m1_rdata, m0_rdata, m0_rvalid);
    end
    tick();
  endtask

  task automatic test_starvation();
    m0_drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    m1_drive(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    for (int c = 0; c < 15; c++) begin
      logic exp1;
      exp1 = ((c % 5) == 4);
      #1;
      n_checks++;
      if ({m0_gnt, m1_gnt, ram_req} !== {~exp1, exp1, 1'b1}) begin
        n_fail++;
        $display("FAIL starve_grant c=%0d got gnt0=%b gnt1=%b req=%b want %b %b 1",
                 c, m0_gnt, m1_gnt, ram_req, ~exp1, exp1);
      end
      n_checks++;
      if (int'(dut.starve_cnt_q) != (c % 5)) begin
        n_fail++;
        $display("FAIL starve_count c=%0d got %0d want %0d", c, dut.starve_cnt_q, c % 5);
      end
      n_checks++;
      if (m0_rvalid === 1'b1 && m1_rvalid === 1'b1) begin
        n_fail++;
        $display("FAIL starve_dual_rvalid c=%0d got rv0=1 rv1=1 want at most one", c);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_byte_enable();
    m0_drive(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
    tick();
    idle();
    m1_drive(1'b1, 1'b1, 4'b0010, 32'h0000_0020, 32'h0000_AB00);
    #1;
    n_checks++;
    if (!(m1_gnt === 1'b1 && ram_be === 4'b0010 && ram_wdata === 32'h0000_AB00)) begin
      n_fail++;
      $display("FAIL be_write got gnt1=%b be=%b wdata=%h want 1 0010 0000ab00",
               m1_gnt, ram_be, ram_wdata);
    end
    tick();
    m1_drive(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    tick();
    idle();
    #1;
    n_checks++;
    if (!(m1_rvalid === 1'b1 && m1_rdata === 32'h1122_AB44)) begin
      n_fail++;
      $display("FAIL be_readback got rv1=%b rd1=%h want 1 1122ab44", m1_rvalid, m1_rdata);
    end
    tick();
  endtask

  task automatic test_routing();
    m0_drive(1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'hA0A0_A0A0);
    tick();
    m0_drive(1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'hB1B1_B1B1);
    tick();
    idle();
    tick();
    m0_drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL route_k got gnt0=%b gnt1=%b rv0=%b rv1=%b want 1 0 0 0",
               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
    end
    tick();
    idle();
    m1_drive(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    #1;
    n_checks++;
    if (!(m1_gnt === 1'b1 && m0_rvalid === 1'b1 && m0_rdata === 32'hA0A0_A0A0 &&
          m1_rvalid === 1'b0 && m1_rdata === 32'h0)) begin
      n_fail++;
      $display("FAIL route_k1 got gnt1=%b rv0=%b rd0=%h rv1=%b rd1=%h want 1 1 a0a0a0a0 0 0",
               m1_gnt, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (!(m1_rvalid === 1'b1 && m1_rdata === 32'hB1B1_B1B1 && m0_rvalid === 1'b0 &&
          m0_rdata === 32'h0)) begin
      n_fail++;
      $display("FAIL route_k2 got rv1=%b rd1=%h rv0=%b rd0=%h want 1 b1b1b1b1 0 0",
               m1_rvalid, m1_rdata, m0_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    m1_drive(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    #1;
    n_checks++;
    if (m1_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_grant got gnt1=%b want 1", m1_gnt);
    end
    tick();
    rst = 1'b1;
    idle();
    #1;
    n_checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midop_no_rvalid got rv0=%b rv1=%b want 0 0", m0_rvalid, m1_rvalid);
    end
    tick();
    m0_drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
    m1_drive(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      logic exp1;
      exp1 = (c == 4);
      #1;
      if (c == 0) begin
        n_checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
          n_fail++;
          $display("FAIL midop_release_rvalid got rv0=%b rv1=%b want 0 0", m0_rvalid, m1_rvalid);
        end
      end
      n_checks++;
      if ({m0_gnt, m1_gnt} !== {~exp1, exp1} || int'(dut.starve_cnt_q) != c) begin
        n_fail++;
        $display("FAIL midop_wait c=%0d got gnt0=%b gnt1=%b cnt=%0d want %b %b %0d",
                 c, m0_gnt, m1_gnt, dut.starve_cnt_q, ~exp1, exp1, c);
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_cross_master();
    test_starvation();
    test_byte_enable();
    test_routing();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miriscv_data_arbiter.md
# miriscv_data_arbiter

Two-master arbiter in front of the single data port of `miriscv_ram`. It lets the core load-store unit (master 0) and a DMA/program-loader engine (master 1) share data memory. Master 0 has fixed priority; a starvation counter guarantees master 1 a grant after a bounded wait. The arbiter also routes the RAM's one-cycle-latency read data back to the master that issued the request.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive cycles master 1 may be denied while requesting, before it is forced to win. Legal range 1..255.

Ports:
- `clk_i` in 1: single clock; all state on its rising edge.
- `rst_i` in 1: synchronous, active-high reset. The top level drives the RAM's `rst_n_i` with `~rst_i`.
- `m0_req_i` / `m1_req_i` in 1: access request.
- `m0_we_i` / `m1_we_i` in 1: 1 = write, 0 = read.
- `m0_be_i` / `m1_be_i` in 4: byte enables. Used only when the access is a write.
- `m0_addr_i` / `m1_addr_i` in 32: byte address.
- `m0_wdata_i` / `m1_wdata_i` in 32: write data.
- `m0_gnt_o` / `m1_gnt_o` out 1: request accepted this cycle.
- `m0_rvalid_o` / `m1_rvalid_o` out 1: response for the access granted in the previous cycle.
- `m0_rdata_o` / `m1_rdata_o` out 32: read data. Valid when the matching rvalid is high; 0 otherwise.
- `ram_req_o`, `ram_we_o` out 1; `ram_be_o` out 4; `ram_addr_o`, `ram_wdata_o` out 32: RAM data port.
- `ram_rdata_i` in 32: RAM registered read data.

## Operation
- Grant logic is combinational and issues at most one grant per cycle.
  - `m1_gnt_o = m1_req_i & (~m0_req_i | starve_hit)`, where `starve_hit = (starve_cnt_q == STARVE_LIMIT)`.
  - `m0_gnt_o = m0_req_i & ~m1_gnt_o`.
- RAM mux:
  - `ram_req_o = m0_gnt_o | m1_gnt_o`.
  - `ram_we_o`, `ram_be_o`, `ram_addr_o` and `ram_wdata_o` come from the granted master.
  - When nothing is granted, all RAM port outputs are 0.
- Starvation counter `starve_cnt_q`, width `$clog2(STARVE_LIMIT+1)`:
  - increments when `m1_req_i & ~m1_gnt_o`;
  - clears to 0 when `m1_gnt_o` is high or `m1_req_i` is low;
  - saturates at `STARVE_LIMIT`; it can never exceed it, because reaching it forces a grant.
- Response tracking registers:
  - `resp_valid_q <= ram_req_o` and `resp_owner_q <= m1_gnt_o`, both updated every cycle.
  - `mX_rvalid_o = resp_valid_q & (resp_owner_q == X) & ~rst_i`.
  - `mX_rdata_o = mX_rvalid_o ? ram_rdata_i : 0`.
  - Writes also produce an rvalid as an acknowledge; its rdata is the pre-write word returned by the RAM and is don't-care.
- While `rst_i` is high:
  - every grant, `ram_req_o` and rvalid is forced to 0, regardless of the requests;
  - `starve_cnt_q <= 0` and `resp_valid_q <= 0`.
- Master obligation: hold req and all request fields stable until gnt. The arbiter does not check this.
- Grants never depend on outstanding responses. Back-to-back grants to either master, or alternating grants, are allowed every cycle.

## Timing
- Grant latency: 0 cycles. Grant is asserted in the same cycle as the request when arbitration is won.
- Response latency: exactly 1 cycle. rvalid and rdata are high in the cycle after the grant, for exactly one cycle.
- Worst-case master 1 wait under continuous master 0 traffic: `STARVE_LIMIT` denied cycles, then a grant in the next cycle.
  - Continuous contention therefore gives the pattern: master 0 granted `STARVE_LIMIT` cycles, then master 1 granted 1 cycle.
- No simultaneous rvalid: at most one of `m0_rvalid_o` / `m1_rvalid_o` is high in any cycle.
- Reset mid-operation:
  - an access granted in the cycle before `rst_i` rises gets no rvalid;
  - the first cycle after `rst_i` falls, both rvalids are 0 and master 0 wins any contention.
- Reset values of all outputs: 0.

## Test plan
- Reset: `rst_i` high 3 cycles with both reqs high -> all gnt, `ram_req_o` and rvalid are 0. In the first cycle after release, `m0_gnt_o` = 1 and `m1_gnt_o` = 0.
- Cross-master data: master 0 writes 0xDEADBEEF to 0x10 with be 0xF. Next cycle master 1 reads 0x10 -> `m1_rvalid_o` one cycle later with `m1_rdata_o` = 0xDEADBEEF, and `m0_rdata_o` = 0.
- Starvation, `STARVE_LIMIT` = 4, both reqs held high for 15 cycles -> master 0 granted in cycles 0-3, 5-8 and 10-13; master 1 granted in cycles 4, 9 and 14. The counter reads 0 after each master 1 grant.
- Byte enables: word 0x20 holds 0x11223344; master 1 writes 0x0000AB00 with be 0b0010, then reads 0x20 -> 0x1122AB44.
- Routing: master 0 reads A = 0x0 in cycle k and master 1 reads B = 0x4 in cycle k+1 -> `m0_rvalid_o` only in k+1 with mem[0]; `m1_rvalid_o` only in k+2 with mem[1]; never both high together.
- Reset mid-op: master 1 read granted in cycle k and `rst_i` high in cycle k+1 -> `m1_rvalid_o` = 0 in k+1. After release, the counter is 0 and master 1 waits the full 4 cycles under contention.
